ifetch_queue: RTL and testbench

//  Fetch stage directly downstream of the PC register. Owns the fetch address,

---
 rtl/riscv_pkg.sv | 15 +
 rtl/ifq_fifo.sv | 56 +++++
 rtl/ifetch_queue.sv | 107 ++++++++++
 tb/tb_ifetch_queue.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-side constants: datapath width, instruction size and reset vector.
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;
  localparam logic [31:0]     NOP              = 32'h0000_0013;

  // Word-align a fetch address; the low two bits never reach memory.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous instruction FIFO with flush; head data reads as zero when empty.
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A full queue may still accept a write when the head leaves in the same cycle.
  assign do_wr = wr_en && !flush && (!full || rd_en);
  assign do_rd = rd_en && !flush && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: owns the fetch PC, issues in-order word requests under a credit
// limit, buffers responses, and squashes everything in flight on a redirect.
module ifetch_queue #(
  parameter int                    XLEN     = riscv_pkg::XLEN,
  parameter int                    DEPTH    = 4,
  parameter logic [XLEN-1:0]       RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            if_ready
);

  import riscv_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] target_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   count;
  logic [CW:0]     inflight;
  logic            credit;
  logic            req_fire;
  logic            rsp_keep;
  logic            deq;
  logic            q_full;
  logic            q_empty;
  logic [31:0]     head_data;

  assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};

  // Queue entries plus requests still in flight can never exceed the queue,
  // so a returning response always has a slot and is never back-pressured.
  assign inflight = {1'b0, count} + {1'b0, outstanding};
  assign credit   = (inflight < (CW+1)'(DEPTH));

  assign imem_req_valid = !reset && !redirect_valid && credit;
  assign imem_req_addr  = fpc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_keep = imem_rsp_valid && !redirect_valid && (drop == '0);
  assign deq      = if_valid && if_ready && !redirect_valid;

  assign if_valid = !q_empty;
  assign if_instr = head_data;
  assign if_pc    = head_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc         <= RESET_PC;
      head_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect_valid) begin
      fpc         <= target_pc;
      head_pc     <= target_pc;
      outstanding <= outstanding - CW'(imem_rsp_valid);
      // Every surviving in-flight response is stale, including ones already marked.
      drop        <= outstanding - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fpc     <= fpc + XLEN'(INSTR_BYTES);
      if (deq)      head_pc <= head_pc + XLEN'(INSTR_BYTES);
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (drop != '0)) drop <= drop - 1'b1;
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (redirect_valid),
    .wr_en   (rsp_keep),
    .wr_data (imem_rsp_data),
    .rd_en   (deq),
    .rd_data (head_data),
    .count   (count),
    .full    (q_full),
    .empty   (q_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(imem_rsp_valid && (outstanding == '0)))
        else $error("ifetch_queue: response with no request outstanding");
      assert (inflight <= (CW+1)'(DEPTH))
        else $error("ifetch_queue: queue plus in-flight exceeds depth");
      assert (!(rsp_keep && q_full && !deq))
        else $error("ifetch_queue: response written into a full queue");
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;

  always #5 clk = ~clk;

  ifetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready)
  );

  // Memory model: each accepted request returns after lat cycles, tagged with
  // the redirect epoch it was issued in so stale returns can be recognised.
  typedef struct packed {
    logic [31:0] addr;
    int          due;
    int          ep;
  } req_t;

  req_t        memq[$];
  logic [31:0] fq[$];
  int          cyc, epoch, lat, last_due;
  logic [31:0] next_req, next_del, prev_addr;
  int          tests, fails, ndeq;
  logic        saw_wrap, dut_fire;
  logic        s_req_valid, s_if_valid;
  logic [31:0] s_req_addr, s_if_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory response, check outputs, advance the model.
  task automatic step();
    logic        exp_credit, fire, deq, keep;
    logic [31:0] keep_addr;
    req_t        r;
    int          due;
    imem_rsp_valid = (memq.size() != 0) && (memq[0].due == cyc);
    imem_rsp_data  = imem_rsp_valid ? mem_word(memq[0].addr) : 32'h0;
    #1;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_if_valid  = if_valid;
    s_if_pc     = if_pc;
    dut_fire    = imem_req_valid && imem_req_ready;

    exp_credit = !redirect_valid && ((fq.size() + memq.size()) < DEPTH);
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_credit});
    chk("if_valid", {31'b0, if_valid}, {31'b0, fq.size() != 0});
    if (fq.size() != 0) begin
      chk("if_pc", if_pc, fq[0]);
      chk("if_instr", if_instr, mem_word(fq[0]));
    end

    fire = exp_credit && imem_req_ready;
    if (fire) begin
      chk("req_addr", imem_req_addr, next_req);
      if (imem_req_addr == 32'h0 && prev_addr == 32'hFFFF_FFFC) saw_wrap = 1'b1;
      prev_addr = imem_req_addr;
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{addr: next_req, due: due, ep: epoch});
      next_req += 32'd4;
    end

    deq = (fq.size() != 0) && if_ready && !redirect_valid;
    if (if_valid && if_ready && !redirect_valid) ndeq++;
    if (deq) begin
      chk("order_pc", if_pc, next_del);
      next_del += 32'd4;
    end

    keep = 1'b0;
    keep_addr = 32'h0;
    if (imem_rsp_valid) begin
      r = memq.pop_front();
      keep = !redirect_valid && (r.ep == epoch);
      keep_addr = r.addr;
    end
    if (redirect_valid) begin
      epoch++;
      next_req = redirect_pc & ~32'h3;
      next_del = redirect_pc & ~32'h3;
    end

    @(posedge clk);
    if (redirect_valid) fq.delete();
    else begin
      if (deq) void'(fq.pop_front());
      if (keep) fq.push_back(keep_addr);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int nf, d0, k;
    tests = 0; fails = 0; ndeq = 0; cyc = 0; epoch = 0; lat = 1; last_due = -1;
    next_req = 32'h0; next_del = 32'h0; prev_addr = 32'h0; saw_wrap = 1'b0;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; if_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    reset = 1'b0;

    // 1: streaming at full rate from the reset vector
    step();
    chk("t1_first_valid", {31'b0, s_req_valid}, 32'h1);
    chk("t1_first_addr", s_req_addr, 32'h0);
    repeat (12) step();
    chk("t1_throughput", {31'b0, ndeq >= 9}, 32'h1);

    // 2: decode stalled, exactly DEPTH requests accepted, then drained in order
    if_ready = 1'b0;
    redirect(32'h300);
    nf = 0;
    repeat (10) begin step(); nf += int'(dut_fire); end
    chk("t2_accepted", nf, 4);
    chk("t2_req_stalled", {31'b0, s_req_valid}, 32'h0);
    if_ready = 1'b1;
    d0 = ndeq;
    repeat (8) step();
    chk("t2_drained", {31'b0, (ndeq - d0) >= 4}, 32'h1);

    // 3: latency 3, redirect with two requests in flight
    lat = 3;
    for (int i = 0; i < 20 && memq.size() != 2; i++) step();
    redirect(32'h100);
    k = 0;
    do begin step(); k++; end while (!s_if_valid && k < 30);
    chk("t3_valid", {31'b0, s_if_valid}, 32'h1);
    chk("t3_first_pc", s_if_pc, 32'h100);

    // 4: redirect with 3 queued and a response landing in the same cycle
    lat = 1;
    if_ready = 1'b0;
    redirect(32'h500);
    for (int i = 0; i < 20 && !(fq.size() == 3 && memq.size() != 0 && memq[0].due == cyc); i++)
      step();
    redirect(32'h200);
    step();
    chk("t4_if_empty", {31'b0, s_if_valid}, 32'h0);
    chk("t4_req_valid", {31'b0, s_req_valid}, 32'h1);
    chk("t4_next_addr", s_req_addr, 32'h200);
    if_ready = 1'b1;
    repeat (6) step();

    // 5: back-to-back redirects, the second wins
    lat = 2;
    repeat (4) step();
    redirect_valid = 1'b1; redirect_pc = 32'h40; step();
    redirect_pc = 32'h80; step();
    redirect_valid = 1'b0;
    k = 0;
    do begin step(); k++; end while (!s_if_valid && k < 30);
    chk("t5_first_pc", s_if_pc, 32'h80);
    repeat (10) step();

    // 6: unaligned redirect target
    redirect(32'h103);
    step();
    chk("t6_addr", s_req_addr, 32'h100);
    repeat (4) step();

    // 7: fetch address wraps at the top of the address space
    saw_wrap = 1'b0;
    lat = 1;
    redirect(32'hFFFF_FFF8);
    repeat (8) step();
    chk("t7_wrap", {31'b0, saw_wrap}, 32'h1);

    // 8: random memory ready, decode ready, latency and redirects
    d0 = ndeq;
    for (int i = 0; i < 600; i++) begin
      imem_req_ready = ($urandom_range(1, 0) == 1);
      if_ready       = ($urandom_range(3, 0) != 0);
      if ($urandom_range(31, 0) == 0) lat = $urandom_range(4, 1);
      redirect_valid = ($urandom_range(39, 0) == 0);
      redirect_pc    = $urandom & 32'h0000_0FFF;
      step();
    end
    redirect_valid = 1'b0; imem_req_ready = 1'b1; if_ready = 1'b1;
    repeat (30) step();
    chk("t8_progress", {31'b0, (ndeq - d0) > 50}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
